cache_assoc: RTL and testbench

Parametrised set-associative, write-back, write-allocate data cache for the pipeline's memory stage. It extends the single-word direct-mapped cache group to multi-word lines, `WAYS` ways with tree pseudo-LRU replacement, and a built-in miss engine. The miss engine writes back dirty victims and refills lines over a word-granular request/acknowledge memory port. It sits between the CPU data port and the memory/bus bridge.

---
 rtl/cache_assoc.sv | 239 +++++++++++++++++++++++
 tb/tb_cache_assoc.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc.sv
// Set-associative write-back/write-allocate data cache with tree pseudo-LRU replacement
// and a word-serial miss engine (dirty victim write-back, then line refill).
module cache_assoc #(
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int SB  = $clog2(SETS);
  localparam int WB  = $clog2(WORDS);
  localparam int LV  = $clog2(WAYS);
  localparam int WYB = (WAYS > 1) ? LV : 1;
  localparam int PW  = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int TB  = 32 - SB - WB - 2;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_RF} state_t;

  logic [WAYS-1:0] r_valid [SETS];
  logic [WAYS-1:0] r_dirty [SETS];
  logic [PW-1:0]   r_plru  [SETS];
  logic [TB-1:0]   r_tag   [SETS][WAYS];
  logic [31:0]     r_data  [SETS][WAYS][WORDS];

  state_t          r_state, w_state_n;
  logic [WB-1:0]   r_cnt, w_cnt_n;
  logic [WYB-1:0]  r_vway, w_vway_n;
  logic [TB-1:0]   r_mtag, w_mtag_n;
  logic [SB-1:0]   r_mset, w_mset_n;
  logic            r_mem_req, r_mem_we;
  logic [31:0]     r_mem_addr, r_mem_wdata;
  logic            w_mreq_n, w_mwe_n;
  logic [31:0]     w_maddr_n, w_mwdata_n;

  logic [TB-1:0]   w_tag;
  logic [SB-1:0]   w_set;
  logic [WB-1:0]   w_word;
  logic [1:0]      w_off;
  logic            w_hit, w_acc, w_miss, w_ack, w_last, w_vic_dirty;
  logic [WYB-1:0]  w_hway, w_vic;

  // Heap-ordered tree: node n has children 2n+1 / 2n+2; a bit of 0 points the victim left.
  function automatic logic [WYB-1:0] plru_victim(input logic [PW-1:0] t);
    int node;
    node = 0;
    for (int l = 0; l < LV; l++) node = 2 * node + 1 + int'(t[node]);
    return WYB'(node - (WAYS - 1));
  endfunction

  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] t, input logic [WYB-1:0] w);
    logic [PW-1:0] res;
    logic          b;
    int            node;
    res  = t;
    node = 0;
    for (int l = 0; l < LV; l++) begin
      b         = w[LV-1-l];
      res[node] = ~b;
      node      = 2 * node + 1 + int'(b);
    end
    return res;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [3:0] m);
    logic [31:0] lanes;
    logic [31:0] res;
    lanes = (sz == 2'b00) ? {4{d[7:0]}} : (sz == 2'b01) ? {2{d[15:0]}} : d;
    res   = old;
    for (int b = 0; b < 4; b++) if (m[b]) res[8*b +: 8] = lanes[8*b +: 8];
    return res;
  endfunction

  assign w_tag  = addr[31 -: TB];
  assign w_set  = addr[WB+2 +: SB];
  assign w_word = addr[2 +: WB];
  assign w_off  = addr[1:0];

  always_comb begin
    w_hit  = 1'b0;
    w_hway = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (r_valid[w_set][i] && (r_tag[w_set][i] == w_tag)) begin
        w_hit  = 1'b1;
        w_hway = WYB'(i);
      end
    end
  end

  // Invalid ways take precedence over the PLRU choice; descending scan leaves the lowest.
  always_comb begin
    w_vic = plru_victim(r_plru[w_set]);
    for (int i = WAYS - 1; i >= 0; i--) if (!r_valid[w_set][i]) w_vic = WYB'(i);
  end

  assign w_vic_dirty = r_valid[w_set][w_vic] & r_dirty[w_set][w_vic];
  assign w_acc  = (r_state == S_IDLE) & req & w_hit;
  assign w_miss = (r_state == S_IDLE) & req & ~w_hit;
  assign w_ack  = mem_ack & r_mem_req;
  assign w_last = (r_cnt == WB'(WORDS - 1));

  assign ready     = w_acc;
  assign rdata     = (w_acc & ~we) ? r_data[w_set][w_hway][w_word] : 32'h0;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_vway_n  = r_vway;
    w_mtag_n  = r_mtag;
    w_mset_n  = r_mset;
    case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          w_vway_n  = w_vic;
          w_mtag_n  = w_tag;
          w_mset_n  = w_set;
          w_cnt_n   = '0;
          w_state_n = w_vic_dirty ? S_WB : S_RF;
        end
      end
      S_WB: begin
        if (w_ack) begin
          w_cnt_n = r_cnt + 1'b1;
          if (w_last) begin
            w_cnt_n   = '0;
            w_state_n = S_RF;
          end
        end
      end
      S_RF: begin
        if (w_ack) begin
          w_cnt_n = r_cnt + 1'b1;
          if (w_last) begin
            w_cnt_n   = '0;
            w_state_n = S_IDLE;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Memory port is registered from the next-state view so it is stable until acked.
  always_comb begin
    w_mreq_n   = 1'b0;
    w_mwe_n    = 1'b0;
    w_maddr_n  = '0;
    w_mwdata_n = '0;
    case (w_state_n)
      S_WB: begin
        w_mreq_n   = 1'b1;
        w_mwe_n    = 1'b1;
        w_maddr_n  = {r_tag[w_mset_n][w_vway_n], w_mset_n, w_cnt_n, 2'b00};
        w_mwdata_n = r_data[w_mset_n][w_vway_n][w_cnt_n];
      end
      S_RF: begin
        w_mreq_n  = 1'b1;
        w_maddr_n = {w_mtag_n, w_mset_n, w_cnt_n, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_vway      <= '0;
      r_mtag      <= '0;
      r_mset      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_vway      <= w_vway_n;
      r_mtag      <= w_mtag_n;
      r_mset      <= w_mset_n;
      r_mem_req   <= w_mreq_n;
      r_mem_we    <= w_mwe_n;
      r_mem_addr  <= w_maddr_n;
      r_mem_wdata <= w_mwdata_n;
      if (w_acc) begin
        r_plru[w_set] <= plru_touch(r_plru[w_set], w_hway);
        if (we) r_dirty[w_set][w_hway] <= 1'b1;
      end
      if ((r_state == S_WB) && w_ack && w_last) r_dirty[r_mset][r_vway] <= 1'b0;
      if ((r_state == S_RF) && w_ack && w_last) begin
        r_valid[r_mset][r_vway] <= 1'b1;
        r_dirty[r_mset][r_vway] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc && we)
      r_data[w_set][w_hway][w_word] <= store_merge(r_data[w_set][w_hway][w_word], wdata, size,
                                                   lane_mask(size, w_off));
    if ((r_state == S_RF) && w_ack) begin
      r_data[r_mset][r_vway][r_cnt] <= mem_rdata;
      if (w_last) r_tag[r_mset][r_vway] <= r_mtag;
    end
  end

endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench for cache_assoc (16 sets, 2 ways, 4 words) with a behavioural memory
// responder that logs every acknowledged word transaction.
module tb_cache_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  size = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_delay = 0;
  int ack_count = 0;
  int stab_err  = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;
  txn_t log_q[$];
  logic [31:0] mem [logic [31:0]];

  cache_assoc #(.SETS(16), .WAYS(2), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .size(size), .wdata(wdata),
    .ready(ready), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  // Memory responder: acks each word after ack_delay waiting cycles, checks port stability.
  initial begin : responder
    int          wc;
    logic [31:0] sa, sd;
    logic        sw;
    wc = 0;
    sa = '0;
    sd = '0;
    sw = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (rst === 1'b1 && mem_req === 1'b1) begin
        if (wc == 0) begin
          sa = mem_addr;
          sw = mem_we;
          sd = mem_wdata;
        end else if (mem_addr !== sa || mem_we !== sw || mem_wdata !== sd) begin
          stab_err++;
        end
        if (wc >= ack_delay) begin
          mem_ack = 1'b1;
          ack_count++;
          log_q.push_back({mem_we, mem_addr, mem_wdata});
          if (mem_we) mem[mem_addr] = mem_wdata;
          else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : (32'hD000_0000 | mem_addr);
          wc = 0;
        end else begin
          wc++;
        end
      end else begin
        wc = 0;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that completes the access.
  task automatic access(input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output int cyc);
    we = w; addr = a; size = s; wdata = d; req = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (ready !== 1'b1 && cyc < 500) begin
      cyc++;
      @(negedge clk);
    end
    if (ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL access_timeout: addr %h no ready after %0d cycles", a, cyc);
    end
    rd = rdata;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    req = 1'b1; addr = 32'h10;
    #10;
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    logic [31:0] rd;
    int cyc;
    log_q.delete();
    access(1'b0, 32'h10, 2'b10, 32'h0, rd, cyc);
    n_tests++; if (cyc !== 5) begin n_fail++; $display("FAIL cold_latency: got %0d want 5", cyc); end
    n_tests++; if (rd !== 32'hA0) begin n_fail++; $display("FAIL cold_rdata: got %h want a0", rd); end
    n_tests++; if (log_q.size() !== 4) begin n_fail++; $display("FAIL cold_txn_count: got %0d want 4", log_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= log_q.size() || log_q[i].a !== 32'h10 + 4*i || log_q[i].we !== 1'b0) begin
        n_fail++; $display("FAIL cold_refill_addr%0d: got %h want %h read", i,
                           (i < log_q.size()) ? log_q[i].a : 32'hx, 32'h10 + 4*i);
      end
    end
    log_q.delete();
    access(1'b0, 32'h14, 2'b10, 32'h0, rd, cyc);
    n_tests++; if (cyc !== 0) begin n_fail++; $display("FAIL hit_latency: got %0d want 0", cyc); end
    n_tests++; if (rd !== 32'hA1) begin n_fail++; $display("FAIL hit_rdata: got %h want a1", rd); end
    n_tests++; if (log_q.size() !== 0) begin n_fail++; $display("FAIL hit_no_mem: got %0d txns want 0", log_q.size()); end
  endtask

  task automatic test_partial_stores();
    logic [31:0] rd;
    int cyc;
    access(1'b1, 32'h13, 2'b00, 32'hFF, rd, cyc);
    n_tests++; if (cyc !== 0) begin n_fail++; $display("FAIL byte_store_latency: got %0d want 0", cyc); end
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL store_rdata_zero: got %h want 0", rd); end
    access(1'b0, 32'h10, 2'b10, 32'h0, rd, cyc);
    n_tests++; if (rd !== 32'hFF0000A0) begin n_fail++; $display("FAIL byte_merge: got %h want ff0000a0", rd); end
    access(1'b1, 32'h16, 2'b01, 32'hBEEF, rd, cyc);
    n_tests++; if (cyc !== 0) begin n_fail++; $display("FAIL half_store_latency: got %0d want 0", cyc); end
    access(1'b0, 32'h14, 2'b10, 32'h0, rd, cyc);
    n_tests++; if (rd !== 32'hBEEF00A1) begin n_fail++; $display("FAIL half_merge: got %h want beef00a1", rd); end
  endtask

  task automatic test_replacement();
    logic [31:0] rd;
    int cyc;
    logic [31:0] exp_wd [4];
    exp_wd[0] = 32'hFF0000A0; exp_wd[1] = 32'hBEEF00A1; exp_wd[2] = 32'hA2; exp_wd[3] = 32'hA3;
    access(1'b0, 32'h110, 2'b10, 32'h0, rd, cyc);
    n_tests++; if (cyc !== 5 || rd !== 32'hD0000110) begin n_fail++; $display("FAIL fill_way1: got %0d/%h want 5/d0000110", cyc, rd); end
    access(1'b0, 32'h10, 2'b10, 32'h0, rd, cyc);
    n_tests++; if (cyc !== 0 || rd !== 32'hFF0000A0) begin n_fail++; $display("FAIL touch_way0: got %0d/%h want 0/ff0000a0", cyc, rd); end
    log_q.delete();
    access(1'b0, 32'h310, 2'b10, 32'h0, rd, cyc);
    n_tests++; if (cyc !== 5) begin n_fail++; $display("FAIL clean_evict_latency: got %0d want 5", cyc); end
    n_tests++; if (rd !== 32'hD0000310) begin n_fail++; $display("FAIL clean_evict_rdata: got %h want d0000310", rd); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= log_q.size() || log_q[i].we !== 1'b0 || log_q[i].a !== 32'h310 + 4*i) begin
        n_fail++; $display("FAIL clean_evict_txn%0d: got %h want %h read", i,
                           (i < log_q.size()) ? log_q[i].a : 32'hx, 32'h310 + 4*i);
      end
    end
    log_q.delete();
    access(1'b0, 32'h410, 2'b10, 32'h0, rd, cyc);
    n_tests++; if (cyc !== 9) begin n_fail++; $display("FAIL dirty_evict_latency: got %0d want 9", cyc); end
    n_tests++; if (rd !== 32'hD0000410) begin n_fail++; $display("FAIL dirty_evict_rdata: got %h want d0000410", rd); end
    n_tests++; if (log_q.size() !== 8) begin n_fail++; $display("FAIL dirty_evict_count: got %0d want 8", log_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= log_q.size() || log_q[i].we !== 1'b1 || log_q[i].a !== 32'h10 + 4*i || log_q[i].d !== exp_wd[i]) begin
        n_fail++; $display("FAIL writeback%0d: got %h want write %h data %h", i,
                           (i < log_q.size()) ? log_q[i] : 65'hx, 32'h10 + 4*i, exp_wd[i]);
      end
      n_tests++;
      if (i + 4 >= log_q.size() || log_q[i+4].we !== 1'b0 || log_q[i+4].a !== 32'h410 + 4*i) begin
        n_fail++; $display("FAIL refill_after_wb%0d: got %h want read %h", i,
                           (i + 4 < log_q.size()) ? log_q[i+4].a : 32'hx, 32'h410 + 4*i);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] rd;
    int cyc;
    ack_delay = 5;
    stab_err  = 0;
    log_q.delete();
    access(1'b0, 32'h510, 2'b10, 32'h0, rd, cyc);
    n_tests++; if (cyc !== 25) begin n_fail++; $display("FAIL stall_latency: got %0d want 25", cyc); end
    n_tests++; if (stab_err !== 0) begin n_fail++; $display("FAIL stall_stability: got %0d changes want 0", stab_err); end
    n_tests++; if (rd !== 32'hD0000510) begin n_fail++; $display("FAIL stall_rdata: got %h want d0000510", rd); end
    n_tests++; if (log_q.size() !== 4) begin n_fail++; $display("FAIL stall_txn_count: got %0d want 4", log_q.size()); end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd;
    int cyc, base, t;
    log_q.delete();
    base = ack_count;
    we = 1'b0; addr = 32'h610; size = 2'b10; req = 1'b1;
    t = 0;
    while (ack_count < base + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_tests++; if (ack_count < base + 2) begin n_fail++; $display("FAIL midrf_acks: got %0d want 2", ack_count - base); end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midrf_mem_req_drop: got %b want 0", mem_req); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midrf_ready: got %b want 0", ready); end
    req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    log_q.delete();
    access(1'b0, 32'h610, 2'b10, 32'h0, rd, cyc);
    n_tests++; if (cyc !== 5) begin n_fail++; $display("FAIL midrf_rerefill_latency: got %0d want 5", cyc); end
    n_tests++; if (rd !== 32'hD0000610) begin n_fail++; $display("FAIL midrf_rdata: got %h want d0000610", rd); end
    n_tests++;
    if (log_q.size() !== 4 || log_q[0].a !== 32'h610 || log_q[3].a !== 32'h61C) begin
      n_fail++; $display("FAIL midrf_full_refill: got %0d txns want 4 from 610 to 61c", log_q.size());
    end
    access(1'b0, 32'h410, 2'b10, 32'h0, rd, cyc);
    n_tests++; if (cyc !== 5) begin n_fail++; $display("FAIL midrf_invalidated: got %0d want 5", cyc); end
  endtask

  task automatic test_write_miss();
    logic [31:0] rd;
    int cyc;
    log_q.delete();
    access(1'b1, 32'h20, 2'b10, 32'h12345678, rd, cyc);
    n_tests++; if (cyc !== 5) begin n_fail++; $display("FAIL wmiss_latency: got %0d want 5", cyc); end
    n_tests++;
    if (log_q.size() !== 4 || log_q[0].we !== 1'b0 || log_q[0].a !== 32'h20 || log_q[3].a !== 32'h2C) begin
      n_fail++; $display("FAIL wmiss_refill: got %0d txns want 4 reads from 20 to 2c", log_q.size());
    end
    access(1'b0, 32'h20, 2'b10, 32'h0, rd, cyc);
    n_tests++; if (cyc !== 0 || rd !== 32'h12345678) begin n_fail++; $display("FAIL wmiss_readback: got %0d/%h want 0/12345678", cyc, rd); end
    access(1'b0, 32'h120, 2'b10, 32'h0, rd, cyc);
    n_tests++; if (cyc !== 5) begin n_fail++; $display("FAIL wmiss_fill_way1: got %0d want 5", cyc); end
    log_q.delete();
    access(1'b0, 32'h220, 2'b10, 32'h0, rd, cyc);
    n_tests++; if (cyc !== 9 || rd !== 32'hD0000220) begin n_fail++; $display("FAIL wmiss_evict: got %0d/%h want 9/d0000220", cyc, rd); end
    n_tests++;
    if (log_q.size() !== 8 || log_q[0] !== {1'b1, 32'h20, 32'h12345678} || log_q[1] !== {1'b1, 32'h24, 32'hD0000024}
        || log_q[4].we !== 1'b0 || log_q[4].a !== 32'h220) begin
      n_fail++; $display("FAIL wmiss_writeback: got %0d txns first %h want 8 first write 20 data 12345678", log_q.size(),
                         (log_q.size() > 0) ? log_q[0] : 65'hx);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd0, rd1, rd2;
    int c0, c1, c2;
    time t0;
    t0 = $time;
    access(1'b0, 32'h220, 2'b10, 32'h0, rd0, c0);
    access(1'b0, 32'h120, 2'b10, 32'h0, rd1, c1);
    access(1'b0, 32'h224, 2'b10, 32'h0, rd2, c2);
    n_tests++; if ($time - t0 !== 30) begin n_fail++; $display("FAIL b2b_throughput: got %0t want 30", $time - t0); end
    n_tests++; if (c0 !== 0 || rd0 !== 32'hD0000220) begin n_fail++; $display("FAIL b2b_first: got %0d/%h want 0/d0000220", c0, rd0); end
    n_tests++; if (c1 !== 0 || rd1 !== 32'hD0000120) begin n_fail++; $display("FAIL b2b_second: got %0d/%h want 0/d0000120", c1, rd1); end
    n_tests++; if (c2 !== 0 || rd2 !== 32'hD0000224) begin n_fail++; $display("FAIL b2b_third: got %0d/%h want 0/d0000224", c2, rd2); end
  endtask

  initial begin
    mem[32'h10] = 32'hA0;
    mem[32'h14] = 32'hA1;
    mem[32'h18] = 32'hA2;
    mem[32'h1C] = 32'hA3;
    test_reset();
    test_cold_miss();
    test_partial_stores();
    test_replacement();
    test_stall();
    test_reset_mid_refill();
    test_write_miss();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
